// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 8-bit bytes, with multi-byte frames held under one ss.
// Frames end with a trailing half-period (ss low, sck low) followed by an ss-high gap.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic       clkOut,
  input  logic       reset_network,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, TRAIL, GAP} state_e;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(SS_GAP - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] half_q, half_d;
  logic [7:0] txsh_q, txsh_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       last_q, last_d;

  logic       half_end;
  logic       accept;

  assign half_end = (cnt_q == DIV_M1);
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clkOut) begin
    if (reset_network) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      txsh_q     <= '0;
      rxsh_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      txsh_q     <= txsh_d;
      rxsh_q     <= rxsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    txsh_d     = txsh_q;
    rxsh_d     = rxsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    case (state_q)
      IDLE, WAIT: begin
        if (accept) begin
          txsh_d  = tx_data;
          last_d  = tx_last;
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (half_end) begin
          cnt_d  = '0;
          half_d = half_q + 4'd1;
          // End of a low half: sck rises on this edge, so miso is captured now.
          if (!half_q[0])
            rxsh_d = {rxsh_q[6:0], miso};
          else if (half_q != 4'd15)
            txsh_d = {txsh_q[6:0], 1'b0};
          if (half_q == 4'd15) begin
            rx_data_d  = rxsh_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? TRAIL : WAIT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TRAIL: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == IDLE) || (state_q == WAIT);
    busy     = (state_q != IDLE);
    sck      = (state_q == SHIFT) && half_q[0];
    ss       = !((state_q == SHIFT) || (state_q == WAIT) || (state_q == TRAIL));
    mosi     = ss ? 1'b0 : txsh_q[7];
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
  end

endmodule
